fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 124 ++++++++++++
 tb/tb_fb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port frame memory between the VGA read path
// and a buffered write path. Reads have strict priority; writes drain in order from a small FIFO.
module fb_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FRAME_WIDTH  = 320,
  parameter int unsigned FRAME_HEIGHT = 240,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  output logic                          wr_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          rd_req,
  input  logic [9:0]                    x_coordinate,
  input  logic [9:0]                    y_coordinate,
  output logic                          rd_valid,
  output logic [23:0]                   rdata,
  output logic                          mem_en,
  output logic                          mem_wen,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned NUM_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned CMP_W      = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic                  rd_in_range_c;
  logic                  rd_hit_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic                  wr_addr_ok_c;
  logic                  push_c;
  logic                  pop_c;

  logic                  s1_valid;
  logic                  s1_hit;

  logic                  unused_rdata;

  // Only the RGB bits of the memory word are returned to the VGA side.
  assign unused_rdata = ^mem_rdata;

  // Read qualification and linear pixel address, computed at full address width.
  assign rd_in_range_c = (32'(x_coordinate) < FRAME_WIDTH) && (32'(y_coordinate) < FRAME_HEIGHT);
  assign rd_hit_c      = !rst && rd_req && rd_in_range_c;
  assign rd_addr_c     = ADDR_WIDTH'(y_coordinate) * ADDR_WIDTH'(FRAME_WIDTH)
                       + ADDR_WIDTH'(x_coordinate);

  // Write acceptance depends only on registered occupancy, never on a same-cycle pop.
  assign wr_ready      = !rst && (fifo_count < DEPTH_CNT);
  assign wr_addr_ok_c  = CMP_W'(wr_addr) < CMP_W'(NUM_PIXELS);
  assign push_c        = wr_valid && wr_ready && wr_addr_ok_c;
  assign pop_c         = !rst && !rd_hit_c && (fifo_count != '0);

  // Memory port: read beats write beats idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_hit_c) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr_c;
    end else if (pop_c) begin
      mem_en    = 1'b1;
      mem_wen   = 1'b1;
      mem_addr  = fifo_addr[rd_ptr];
      mem_wdata = fifo_data[rd_ptr];
    end
  end

  // Write-buffer storage; entries need no reset since occupancy gates every use.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // Buffer pointers/occupancy, two-stage read pipeline and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      s1_valid   <= 1'b0;
      s1_hit     <= 1'b0;
      rd_valid   <= 1'b0;
      rdata      <= '0;
      wr_err     <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      s1_valid <= rd_req;
      s1_hit   <= rd_hit_c;
      rd_valid <= s1_valid;
      rdata    <= s1_hit ? mem_rdata[23:0] : 24'd0;
      wr_err   <= wr_valid && wr_ready && !wr_addr_ok_c;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: stimulus queues expected read data and memory writes,
// a negedge monitor pops and compares whenever rd_valid or a memory write appears.
module tb_fb_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned NPIX = 76800;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          wr_err;
  logic [2:0]    fifo_count;
  logic          rd_req;
  logic [9:0]    x_coordinate;
  logic [9:0]    y_coordinate;
  logic          rd_valid;
  logic [23:0]   rdata;
  logic          mem_en;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] tb_mem [NPIX];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int issue; logic [23:0] data; } rd_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t re;
  wr_exp_t we;

  fb_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_err(wr_err), .fifo_count(fifo_count),
    .rd_req(rd_req), .x_coordinate(x_coordinate), .y_coordinate(y_coordinate),
    .rd_valid(rd_valid), .rdata(rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_wen === 1'b1) begin
        if (mem_addr < NPIX) tb_mem[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= (mem_addr < NPIX) ? tb_mem[mem_addr] : 32'hDEAD_DEAD;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rd_valid and every memory write must match the head of its queue.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got rd_valid with rdata 0x%0h expected none (cycle %0d)", rdata, cyc);
      end else begin
        re = rd_q.pop_front();
        check("rdata", 64'(rdata), 64'(re.data));
        check("rd_latency", 64'(cyc - re.issue), 64'd2);
      end
    end
    if (mem_en === 1'b1 && mem_wen === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: got write addr %0d expected none (cycle %0d)", mem_addr, cyc);
      end else begin
        we = wr_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(we.addr));
        check("wr_data", 64'(mem_wdata), 64'(we.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int x, input int y, input logic [23:0] exp);
    rd_req       = 1'b1;
    x_coordinate = 10'(x);
    y_coordinate = 10'(y);
    rd_q.push_back('{issue: cyc, data: exp});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit expect_write);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    if (expect_write) wr_q.push_back('{addr: a, data: d});
  endtask

  int px [5] = '{0, 319, 10, 0, 7};
  int py [5] = '{0, 239, 1, 240, 100};
  int pa [5] = '{0, 76799, 330, 0, 32007};
  logic [23:0] pd [5] = '{24'h112233, 24'h445566, 24'h778899, 24'h000000, 24'hA0B0C0};

  initial begin
    int w;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; x_coordinate = '0; y_coordinate = '0;
    tb_mem[645]   <= 32'h00AB_CDEF;
    tb_mem[0]     <= 32'h0011_2233;
    tb_mem[76799] <= 32'hFF44_5566;
    tb_mem[330]   <= 32'h0077_8899;
    tb_mem[32007] <= 32'h12A0_B0C0;

    // Reset state
    repeat (3) tick();
    #1;
    check("rst_wr_ready", 64'(wr_ready), 0);
    check("rst_mem_en", 64'(mem_en), 0);
    check("rst_rd_valid", 64'(rd_valid), 0);
    check("rst_fifo_count", 64'(fifo_count), 0);
    tick(); rst = 1'b0; #1;
    check("post_rst_wr_ready", 64'(wr_ready), 1);

    // Single read, then out-of-range reads on each axis
    tick(); rd(5, 2, 24'hABCDEF); #1;
    check("rd_mem_en", 64'(mem_en), 1);
    check("rd_mem_wen", 64'(mem_wen), 0);
    check("rd_mem_addr", 64'(mem_addr), 645);
    tick(); rd(320, 0, 24'h0); #1;
    check("oor_x_mem_en", 64'(mem_en), 0);
    tick(); rd(0, 240, 24'h0); #1;
    check("oor_y_mem_en", 64'(mem_en), 0);

    // Back-to-back reads including frame corners and an out-of-range slot
    for (int i = 0; i < 5; i++) begin
      tick(); rd(px[i], py[i], pd[i]); #1;
      if (py[i] < 240) check("pipe_addr", 64'(mem_addr), 64'(pa[i]));
      else check("pipe_oor_mem_en", 64'(mem_en), 0);
    end
    tick(); rd_req = 1'b0;
    repeat (3) tick();

    // Contention: reads hold the port, buffer fills, writes stall then drain in order
    for (int i = 0; i < 10; i++) begin
      tick(); rd(5, 2, 24'hABCDEF);
      if (i < 4) wr(32'(100 + i), 32'hCAFE_0000 + 32'(i), 1'b1);
      else if (i == 5) wr(32'd200, 32'hDEAD_BEEF, 1'b0);
      else wr_valid = 1'b0;
      #1;
      check("cont_no_wen", 64'(mem_wen), 0);
      if (i < 4) check("cont_wr_ready_open", 64'(wr_ready), 1);
      else begin
        check("cont_fifo_full", 64'(fifo_count), 4);
        check("cont_wr_ready_full", 64'(wr_ready), 0);
      end
    end
    tick(); rd_req = 1'b0; wr_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("drain_wen", 64'(mem_en & mem_wen), 1);
      check("drain_addr", 64'(mem_addr), 64'(100 + j));
      tick();
    end
    #1;
    check("drain_idle", 64'(mem_en), 0);
    check("drain_count", 64'(fifo_count), 0);

    // Out-of-frame write is dropped and flagged one cycle later
    tick(); wr(32'd76800, 32'h1111_1111, 1'b0); #1;
    check("bad_wr_ready", 64'(wr_ready), 1);
    check("bad_wr_mem_en", 64'(mem_en), 0);
    tick(); wr_valid = 1'b0; #1;
    check("bad_wr_err", 64'(wr_err), 1);
    check("bad_wr_count", 64'(fifo_count), 0);
    check("bad_wr_mem_en2", 64'(mem_en), 0);
    tick(); #1;
    check("bad_wr_err_clear", 64'(wr_err), 0);

    // Simultaneous push and pop at occupancy 2; same address written twice
    tick(); rd(5, 2, 24'hABCDEF); wr(32'd2000, 32'h0000_0A0A, 1'b1);
    tick(); rd(5, 2, 24'hABCDEF); wr(32'd76799, 32'h0000_0B0B, 1'b1);
    tick(); rd_req = 1'b0; wr(32'd2000, 32'h0000_0C0C, 1'b1); #1;
    check("pp_count_before", 64'(fifo_count), 2);
    check("pp_wen", 64'(mem_en & mem_wen), 1);
    check("pp_addr", 64'(mem_addr), 2000);
    tick(); wr_valid = 1'b0; #1;
    check("pp_count_after", 64'(fifo_count), 2);
    repeat (3) tick();
    check("pp_mem_2000", 64'(tb_mem[2000]), 64'h0C0C);
    check("pp_mem_76799", 64'(tb_mem[76799]), 64'h0B0B);
    check("pp_count_drained", 64'(fifo_count), 0);

    // Reset mid-flight: in-flight read and buffered write are both discarded
    tick(); rd_req = 1'b1; x_coordinate = 10'd5; y_coordinate = 10'd2;
    wr(32'd3000, 32'h3333_3333, 1'b0);
    tick(); rst = 1'b1; rd_req = 1'b0; wr_valid = 1'b0; #1;
    check("mf_rst_wr_ready", 64'(wr_ready), 0);
    check("mf_rst_mem_en", 64'(mem_en), 0);
    tick(); rst = 1'b0; #1;
    check("mf_rd_valid", 64'(rd_valid), 0);
    check("mf_count", 64'(fifo_count), 0);
    check("mf_wr_ready", 64'(wr_ready), 1);
    check("mf_mem_en", 64'(mem_en), 0);
    tick(); #1;
    check("mf_rd_valid_next", 64'(rd_valid), 0);

    w = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && w < 20) begin
      tick(); w++;
    end
    check("rd_queue_empty", 64'(rd_q.size()), 0);
    check("wr_queue_empty", 64'(wr_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
